// File: rtl/debug_dump_unit.sv
// debug_dump_unit: snapshots FR/RAM words and streams them over the UART
// tx FIFO as a framed packet (header, payload LSB-first, XOR checksum).
// Ports:
//   clk, rst (async, active-low)
//   fin, db_mode                  halt flag and auto-dump enable
//   datoFR/datoRAM, direccionFR/direccionRAM    pipeline debug read ports
//   rx_empty, r_data, rd_uart     host command FIFO
//   tx_full, wr_uart, w_data      packet output FIFO
//   busy, done                    dump status
module debug_dump_unit #(
   parameter int         DATA_W    = 32,
   parameter int         FR_DEPTH  = 32,
   parameter int         FR_AW     = 5,
   parameter int         RAM_DEPTH = 32,
   parameter int         RAM_AW    = 32,
   parameter int         READ_LAT  = 1,
   parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fin,
   input  logic              db_mode,
   input  logic [DATA_W-1:0] datoFR,
   input  logic [DATA_W-1:0] datoRAM,
   output logic [FR_AW-1:0]  direccionFR,
   output logic [RAM_AW-1:0] direccionRAM,
   input  logic              rx_empty,
   input  logic [7:0]        r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic              wr_uart,
   output logic [7:0]        w_data,
   output logic              busy,
   output logic              done
);

   localparam int N       = (FR_DEPTH > RAM_DEPTH) ? FR_DEPTH : RAM_DEPTH;
   localparam int TOT     = FR_DEPTH + RAM_DEPTH;
   localparam int BPW     = DATA_W / 8;
   localparam int CAP_LEN = N + READ_LAT;
   localparam int CMAX    = (CAP_LEN > TOT) ? CAP_LEN : TOT;
   localparam int CW      = $clog2(CMAX + 1);
   localparam int BW      = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int IW      = (TOT > 1) ? $clog2(TOT) : 1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CAP  = 3'd1;
   localparam logic [2:0] ST_HDR  = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd3;
   localparam logic [2:0] ST_SUM  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     byte_q, byte_d;
   logic [7:0]        sum_q, sum_d;
   logic              fin_q, fin_d;
   logic              arm_q, arm_d;

   logic [DATA_W-1:0] buf_q [TOT];

   logic              idle_like;
   logic              sending;
   logic              trig;
   logic              fin_edge;
   logic              cmd_hit;
   logic [CW-1:0]     fr_a, ram_a;
   logic [CW-1:0]     k;
   logic              samp;
   logic              fr_we, ram_we;
   logic [IW-1:0]     fr_idx, ram_idx;
   logic [DATA_W-1:0] cur_word;
   logic [7:0]        cur_byte;

   always_comb begin
      idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
      sending   = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                  (state_q == ST_SUM);
      busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
      done      = (state_q == ST_DONE);

      // arm_q masks the first cycle after reset so a fin already high
      // is not mistaken for a fresh rising edge
      fin_edge  = fin && !fin_q && arm_q && db_mode;
      cmd_hit   = !rx_empty && (r_data == 8'h44);
      rd_uart   = idle_like && !rx_empty;
      trig      = idle_like && (fin_edge || cmd_hit);

      fr_a  = (cnt_q > CW'(FR_DEPTH - 1)) ? CW'(FR_DEPTH - 1) : cnt_q;
      ram_a = (cnt_q > CW'(RAM_DEPTH - 1)) ? CW'(RAM_DEPTH - 1) : cnt_q;
      direccionFR  = '0;
      direccionRAM = '0;
      if (state_q == ST_CAP) begin
         direccionFR  = FR_AW'(fr_a);
         direccionRAM = RAM_AW'(ram_a);
      end

      // data arriving now belongs to the address driven READ_LAT ago
      k       = cnt_q - CW'(READ_LAT);
      samp    = (state_q == ST_CAP) && (cnt_q >= CW'(READ_LAT));
      fr_we   = samp && (k < CW'(FR_DEPTH));
      ram_we  = samp && (k < CW'(RAM_DEPTH));
      fr_idx  = IW'(k);
      ram_idx = IW'(k + CW'(FR_DEPTH));

      cur_word = buf_q[IW'(cnt_q)];
      cur_byte = 8'(cur_word >> {byte_q, 3'b000});

      wr_uart = sending && !tx_full;
      w_data  = 8'h00;
      unique case (1'b1)
         state_q == ST_HDR:  w_data = HDR_BYTE;
         state_q == ST_DATA: w_data = cur_byte;
         state_q == ST_SUM:  w_data = sum_q;
         default:            w_data = 8'h00;
      endcase

      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      sum_d   = sum_q;
      fin_d   = fin;
      arm_d   = 1'b1;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (trig) begin
               state_d = ST_CAP;
               cnt_d   = '0;
               byte_d  = '0;
               sum_d   = 8'h00;
            end
         end
         ST_CAP: begin
            if (cnt_q == CW'(CAP_LEN - 1)) begin
               state_d = ST_HDR;
               cnt_d   = '0;
               byte_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HDR: begin
            if (!tx_full) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (!tx_full) begin
               sum_d = sum_q ^ cur_byte;
               if (byte_q == BW'(BPW - 1)) begin
                  byte_d = '0;
                  if (cnt_q == CW'(TOT - 1)) state_d = ST_SUM;
                  else cnt_d = cnt_q + 1'b1;
               end else begin
                  byte_d = byte_q + 1'b1;
               end
            end
         end
         ST_SUM: begin
            if (!tx_full) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         byte_q  <= '0;
         sum_q   <= 8'h00;
         fin_q   <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         sum_q   <= sum_d;
         fin_q   <= fin_d;
         arm_q   <= arm_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fr_we)  buf_q[fr_idx]  <= datoFR;
      if (ram_we) buf_q[ram_idx] <= datoRAM;
   end

endmodule
